// File: rtl/core0_mem_responder.sv
// Memory-side responder for core0: program bytes and main words with 1-cycle registered reads,
// plus a host byte-stream loader that clears main memory, loads the program, then releases core0.
// state   | meaning
// CLEAR   | zero main memory one word per cycle
// LOAD    | accept host program bytes into program memory
// RELEASE | one cycle to prefetch prog[0] while core0 is still held in reset
// RUN     | core0 running, core ports live; terminal until reset
`timescale 1ns/1ps
module core0_mem_responder #(
    parameter int WORD_MAG           = 5,
    parameter int PROGRAM_ADDR_WIDTH = 5,
    parameter int MAIN_ADDR_WIDTH    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          core_reset,
    input  logic [PROGRAM_ADDR_WIDTH-1:0] programmem_addr,
    output logic [7:0]                    programmem_read_value,
    input  logic [(1<<WORD_MAG)-1:0]      programmem_write_value,
    input  logic                          programmem_we,
    input  logic [MAIN_ADDR_WIDTH-1:0]    mainmem_read_addr,
    input  logic [MAIN_ADDR_WIDTH-1:0]    mainmem_write_addr,
    output logic [(1<<WORD_MAG)-1:0]      mainmem_read_value,
    input  logic [(1<<WORD_MAG)-1:0]      mainmem_write_value,
    input  logic                          mainmem_we,
    input  logic                          load_valid,
    input  logic [7:0]                    load_data,
    input  logic                          load_last,
    output logic                          load_ready,
    output logic                          load_done
);
    localparam int WORD_WIDTH   = 1 << WORD_MAG;
    localparam int PROGRAM_SIZE = 1 << PROGRAM_ADDR_WIDTH;
    localparam int MEMORY_SIZE  = 1 << MAIN_ADDR_WIDTH;

    localparam logic [1:0] CLEAR   = 2'd0;
    localparam logic [1:0] LOAD    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    localparam logic [1:0] RUN     = 2'd3;

    localparam logic [MAIN_ADDR_WIDTH-1:0]    CLEAR_LAST = MAIN_ADDR_WIDTH'(MEMORY_SIZE - 1);
    localparam logic [PROGRAM_ADDR_WIDTH-1:0] LOAD_LAST  = PROGRAM_ADDR_WIDTH'(PROGRAM_SIZE - 1);
    localparam logic [PROGRAM_ADDR_WIDTH-1:0] PROG_FIRST = '0;

    logic [1:0]                    state;
    logic [MAIN_ADDR_WIDTH-1:0]    clear_cnt;
    logic [PROGRAM_ADDR_WIDTH-1:0] load_cnt;
    logic [7:0]                    prog_mem [PROGRAM_SIZE];
    logic [WORD_WIDTH-1:0]         main_mem [MEMORY_SIZE];
    logic                          transfer;
    logic                          unused_write_bits;

    assign core_reset = (state != RUN);
    assign load_ready = (state == LOAD);
    assign load_done  = (state == RUN);
    assign transfer   = load_valid && load_ready;

    // Only the low byte of a core program write is stored.
    assign unused_write_bits = ^programmem_write_value[WORD_WIDTH-1:8];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            clear_cnt <= '0;
            load_cnt  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clear_cnt <= clear_cnt + MAIN_ADDR_WIDTH'(1);
                    if (clear_cnt == CLEAR_LAST)
                        state <= LOAD;
                end
                LOAD: begin
                    if (transfer) begin
                        load_cnt <= load_cnt + PROGRAM_ADDR_WIDTH'(1);
                        // A full program memory ends the load even without load_last.
                        if (load_last || load_cnt == LOAD_LAST)
                            state <= RELEASE;
                    end
                end
                RELEASE: state <= RUN;
                default: state <= state;
            endcase
        end
    end

    // Storage is deliberately not reset; main memory is zeroed by the CLEAR walk instead.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR)
                main_mem[clear_cnt] <= '0;
            else if (state == RUN && mainmem_we)
                main_mem[mainmem_write_addr] <= mainmem_write_value;

            if (state == LOAD && transfer)
                prog_mem[load_cnt] <= load_data;
            else if (state == RUN && programmem_we)
                prog_mem[programmem_addr] <= programmem_write_value[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            programmem_read_value <= '0;
            mainmem_read_value    <= '0;
        end else begin
            case (state)
                RELEASE: begin
                    programmem_read_value <= prog_mem[PROG_FIRST];
                    mainmem_read_value    <= '0;
                end
                RUN: begin
                    programmem_read_value <= prog_mem[programmem_addr];
                    // Main port is write-first on an address collision.
                    if (mainmem_we && mainmem_write_addr == mainmem_read_addr)
                        mainmem_read_value <= mainmem_write_value;
                    else
                        mainmem_read_value <= main_mem[mainmem_read_addr];
                end
                default: begin
                    programmem_read_value <= programmem_read_value;
                    mainmem_read_value    <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core0_mem_responder.sv
// Self-checking bench for core0_mem_responder: scenario tasks with a read-data scoreboard.
`timescale 1ns/1ps
module tb_core0_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        core_reset;
    logic [4:0]  programmem_addr;
    logic [7:0]  programmem_read_value;
    logic [31:0] programmem_write_value;
    logic        programmem_we;
    logic [1:0]  mainmem_read_addr;
    logic [1:0]  mainmem_write_addr;
    logic [31:0] mainmem_read_value;
    logic [31:0] mainmem_write_value;
    logic        mainmem_we;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
    logic        load_ready;
    logic        load_done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0]  exp_prog [$];
    logic [31:0] exp_main [$];

    core0_mem_responder dut (
        .clk                    (clk),
        .reset                  (reset),
        .core_reset             (core_reset),
        .programmem_addr        (programmem_addr),
        .programmem_read_value  (programmem_read_value),
        .programmem_write_value (programmem_write_value),
        .programmem_we          (programmem_we),
        .mainmem_read_addr      (mainmem_read_addr),
        .mainmem_write_addr     (mainmem_write_addr),
        .mainmem_read_value     (mainmem_read_value),
        .mainmem_write_value    (mainmem_write_value),
        .mainmem_we             (mainmem_we),
        .load_valid             (load_valid),
        .load_data              (load_data),
        .load_last              (load_last),
        .load_ready             (load_ready),
        .load_done              (load_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Counts cycles spent in CLEAR (core held, no ready), bounded.
    task automatic count_clear(output int n);
        n = 0;
        while (core_reset && !load_ready && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, output logic acc);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = l;
        acc        = load_ready;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        n_checks++;
        if ({core_reset, load_ready, load_done} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_ctrl: got core_reset/ready/done=%b required 100", {core_reset, load_ready, load_done});
        end
        n_checks++;
        if (programmem_read_value !== 8'h00 || mainmem_read_value !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_read: got prog=%h main=%h required 00/00000000", programmem_read_value, mainmem_read_value);
        end
        count_clear(n);
        n_checks++;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL reset_clear_len: got %0d cycles required 4", n);
        end
    endtask

    task automatic test_load_basic();
        logic a0, a1, a2;
        logic [7:0] got, e;
        send_byte(8'h11, 1'b0, a0);
        step();
        send_byte(8'h22, 1'b0, a1);
        send_byte(8'h33, 1'b1, a2);
        n_checks++;
        if ({a0, a1, a2} !== 3'b111) begin
            n_fail++;
            $display("FAIL load_accept: got %b required 111", {a0, a1, a2});
        end
        n_checks++;
        if ({core_reset, load_ready, load_done} !== 3'b100) begin
            n_fail++;
            $display("FAIL release_ctrl: got %b required 100", {core_reset, load_ready, load_done});
        end
        step();
        n_checks++;
        if ({core_reset, load_ready, load_done} !== 3'b001 || programmem_read_value !== 8'h11) begin
            n_fail++;
            $display("FAIL run_entry: got ctrl=%b prog=%h required 001/11", {core_reset, load_ready, load_done}, programmem_read_value);
        end
        for (int i = 0; i < 3; i++) begin
            programmem_addr = 5'(i);
            exp_prog.push_back(8'(8'h11 * (i + 1)));
            step();
            got = programmem_read_value;
            e = exp_prog.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL load_prog[%0d]: got %h required %h", i, got, e);
            end
        end
    endtask

    task automatic test_main_port();
        logic [31:0] got, e;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin mainmem_we = 1; mainmem_write_addr = 2; mainmem_write_value = 32'hDEADBEEF; mainmem_read_addr = 2; exp_main.push_back(32'hDEADBEEF); end
                1: begin mainmem_we = 1; mainmem_write_addr = 2; mainmem_write_value = 32'hDEADBEEF; mainmem_read_addr = 1; exp_main.push_back(32'h0); end
                2: begin mainmem_we = 0; mainmem_read_addr = 2; exp_main.push_back(32'hDEADBEEF); end
                default: begin
                    mainmem_we = 1; mainmem_write_addr = 2'(i - 3); mainmem_read_addr = 2'(i - 3);
                    mainmem_write_value = 32'hFFFFFFFF; exp_main.push_back(32'hFFFFFFFF);
                end
            endcase
            step();
            got = mainmem_read_value;
            e = exp_main.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL main_port step %0d: got %h required %h", i, got, e);
            end
        end
        mainmem_we = 0;
    endtask

    task automatic test_clear_after_reset();
        int n;
        logic acc;
        logic [31:0] got, e;
        do_reset();
        count_clear(n);
        n_checks++;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL clear2_len: got %0d cycles required 4", n);
        end
        mainmem_we = 1; mainmem_write_addr = 1; mainmem_read_addr = 1; mainmem_write_value = 32'h12345678;
        step();
        step();
        n_checks++;
        if (mainmem_read_value !== 32'h0 || programmem_read_value !== 8'h00) begin
            n_fail++;
            $display("FAIL idle_ports: got main=%h prog=%h required 00000000/00", mainmem_read_value, programmem_read_value);
        end
        mainmem_we = 0;
        send_byte(8'h5A, 1'b1, acc);
        step();
        for (int i = 0; i < 4; i++) begin
            mainmem_read_addr = 2'(i);
            exp_main.push_back(32'h0);
            step();
            got = mainmem_read_value;
            e = exp_main.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL cleared_main[%0d]: got %h required %h", i, got, e);
            end
        end
    endtask

    task automatic test_overflow();
        int n;
        logic acc;
        logic [7:0] got, e;
        int bad_acc = 0;
        do_reset();
        count_clear(n);
        for (int i = 0; i < 33; i++) begin
            send_byte(8'(i), 1'b0, acc);
            if (acc !== (i < 32)) bad_acc++;
        end
        n_checks++;
        if (bad_acc != 0) begin
            n_fail++;
            $display("FAIL overflow_accept: got %0d wrong ready samples required 0", bad_acc);
        end
        n_checks++;
        if (load_done !== 1'b1 || load_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_run: got done=%b ready=%b required 1/0", load_done, load_ready);
        end
        for (int i = 0; i < 32; i++) begin
            programmem_addr = 5'(i);
            exp_prog.push_back(8'(i));
            step();
            got = programmem_read_value;
            e = exp_prog.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL overflow_prog[%0d]: got %h required %h", i, got, e);
            end
        end
    endtask

    task automatic test_prog_port();
        int n;
        logic acc;
        logic [7:0] got, e;
        do_reset();
        count_clear(n);
        for (int i = 0; i < 8; i++)
            send_byte((i == 7) ? 8'h44 : 8'(8'h40 + i), i == 7, acc);
        step();
        for (int i = 0; i < 2; i++) begin
            programmem_addr = 5'd7;
            programmem_we = (i == 0);
            programmem_write_value = 32'h000001A5;
            exp_prog.push_back((i == 0) ? 8'h44 : 8'hA5);
            step();
            got = programmem_read_value;
            e = exp_prog.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL prog_port step %0d: got %h required %h", i, got, e);
            end
        end
        programmem_we = 0;
    endtask

    task automatic test_reset_mid_load();
        int n;
        logic acc;
        logic [7:0] got, e;
        do_reset();
        count_clear(n);
        programmem_addr = 5'd1; programmem_we = 1; programmem_write_value = 32'h77;
        send_byte(8'hA0, 1'b0, acc);
        send_byte(8'hA1, 1'b0, acc);
        do_reset();
        count_clear(n);
        n_checks++;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL midload_clear_len: got %0d cycles required 4", n);
        end
        programmem_we = 0;
        send_byte(8'hB0, 1'b1, acc);
        step();
        for (int i = 0; i < 3; i++) begin
            programmem_addr = 5'(i);
            exp_prog.push_back((i == 0) ? 8'hB0 : (i == 1) ? 8'hA1 : 8'h42);
            step();
            got = programmem_read_value;
            e = exp_prog.pop_front();
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL midload_prog[%0d]: got %h required %h", i, got, e);
            end
        end
    endtask

    initial begin
        reset = 1; programmem_addr = 0; programmem_write_value = 0; programmem_we = 0;
        mainmem_read_addr = 0; mainmem_write_addr = 0; mainmem_write_value = 0; mainmem_we = 0;
        load_valid = 0; load_data = 0; load_last = 0;
        test_reset();
        test_load_basic();
        test_main_port();
        test_clear_after_reset();
        test_overflow();
        test_prog_port();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t required completion", $time);
        $fatal(1);
    end
endmodule
